// File: rtl/axi4_banked_burst_ram.sv
// Multi-bank AXI4 slave memory back end.
// The AXI front end reports burst starts and handshaked beats. This block then walks the
// FIXED/INCR/WRAP address sequence, decodes each address to a bank and word, applies byte
// strobes on writes and returns registered read data. A write and a read that hit the same
// word in the same cycle are forwarded, so the read sees the new bytes.
// Beats that address a bank beyond USER_NUM_MEM are flagged; their writes are dropped.
module axi4_banked_burst_ram #(
    parameter int C_S_AXI_ADDR_WIDTH = 10,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int OPT_MEM_ADDR_BITS  = 3,
    parameter int USER_NUM_MEM       = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic                              wr_start,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [7:0]                        S_AXI_AWLEN,
    input  logic [1:0]                        S_AXI_AWBURST,
    input  logic                              S_AXI_WVALID,
    input  logic                              axi_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              rd_start,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [7:0]                        S_AXI_ARLEN,
    input  logic [1:0]                        S_AXI_ARBURST,
    input  logic                              rd_beat_req,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     axi_rdata,
    output logic                              rd_data_valid,
    output logic                              rd_last,
    output logic                              wr_done,
    output logic                              oob_err
);

    localparam int AW         = C_S_AXI_ADDR_WIDTH;
    localparam int DW         = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W     = DW / 8;
    localparam int SIZE_BYTES = STRB_W;
    localparam int ADDR_LSB   = $clog2(STRB_W);
    localparam int WORD_BITS  = OPT_MEM_ADDR_BITS + 1;
    localparam int WORDS      = 2 ** WORD_BITS;
    localparam int BANK_BITS  = (USER_NUM_MEM > 1) ? $clog2(USER_NUM_MEM) : 1;

    localparam logic [31:0] NUM_MEM_U = 32'(USER_NUM_MEM);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic {W_IDLE, W_ACTIVE} wstate_t;
    typedef enum logic {R_IDLE, R_ACTIVE} rstate_t;

    // Next beat address. WRAP is honoured only for the legal lengths 2/4/8/16 beats;
    // other WRAP lengths step like INCR. Reserved burst type 11 also steps like INCR.
    function automatic logic [AW-1:0] stepAddr(input logic [AW-1:0] addr,
                                               input logic [7:0]    len,
                                               input logic [1:0]    burst);
        logic [AW-1:0] incr;
        logic [AW-1:0] mask;
        logic [AW-1:0] result;
        incr   = addr + AW'(SIZE_BYTES);
        mask   = AW'(((32'(len) + 32'd1) * 32'(SIZE_BYTES)) - 32'd1);
        result = incr;
        if (burst == BURST_FIXED) begin
            result = addr;
        end else if ((burst == BURST_WRAP) &&
                     ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15))) begin
            result = (addr & ~mask) | (incr & mask);
        end
        return result;
    endfunction

    // Storage: one word array per bank. There is no reset, so contents survive ARESETN.
    logic [DW-1:0] mem [USER_NUM_MEM][WORDS];

    // Write burst state
    wstate_t         wState_q, wState_d;
    logic [AW-1:0]   wAddr_q,  wAddr_d;
    logic [7:0]      wLen_q,   wLen_d;
    logic [1:0]      wBurst_q, wBurst_d;
    logic [7:0]      wCnt_q,   wCnt_d;
    logic            wrDone_q, wrDone_d;

    // Read burst state
    rstate_t         rState_q, rState_d;
    logic [AW-1:0]   rAddr_q,  rAddr_d;
    logic [7:0]      rLen_q,   rLen_d;
    logic [1:0]      rBurst_q, rBurst_d;
    logic [7:0]      rCnt_q,   rCnt_d;
    logic            rdValid_q, rdValid_d;
    logic            rdLast_q,  rdLast_d;
    logic [DW-1:0]   rdData_q,  rdData_d;

    logic            oobErr_q, oobErr_d;

    // Beat qualification and address decode
    logic                  wBeat;
    logic                  rReq;
    logic [WORD_BITS-1:0]  wWord, rWord;
    logic [BANK_BITS-1:0]  wBank, rBank, rBankSafe;
    logic                  wOob, rOob;
    logic                  collide;
    logic [DW-1:0]         rdMerged;

    // A beat arriving on the reset edge must not reach the RAM, so the reset gates the write beat.
    assign wBeat = S_AXI_ARESETN && (wState_q == W_ACTIVE) && S_AXI_WVALID && axi_wready;
    assign rReq  = (rState_q == R_ACTIVE) && rd_beat_req;

    assign wWord = wAddr_q[ADDR_LSB +: WORD_BITS];
    assign wBank = wAddr_q[ADDR_LSB + WORD_BITS +: BANK_BITS];
    assign rWord = rAddr_q[ADDR_LSB +: WORD_BITS];
    assign rBank = rAddr_q[ADDR_LSB + WORD_BITS +: BANK_BITS];

    assign wOob = ({{(32-BANK_BITS){1'b0}}, wBank} >= NUM_MEM_U);
    assign rOob = ({{(32-BANK_BITS){1'b0}}, rBank} >= NUM_MEM_U);

    // An out-of-range read still indexes a real bank; its data is discarded afterwards.
    assign rBankSafe = rOob ? '0 : rBank;

    assign collide = wBeat && !wOob && !rOob && (wBank == rBank) && (wWord == rWord);

    // Write-first forwarding: strobed bytes of a colliding write replace the stored bytes.
    always_comb begin
        rdMerged = mem[rBankSafe][rWord];
        if (collide) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    rdMerged[b*8 +: 8] = S_AXI_WDATA[b*8 +: 8];
                end
            end
        end
    end

    // RAM write port with per-byte enables. Out-of-range beats are dropped.
    always_ff @(posedge S_AXI_ACLK) begin
        if (wBeat && !wOob) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    mem[wBank][wWord][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
                end
            end
        end
    end

    // Write FSM: latch a burst, step the address on each beat and pulse done after the last beat.
    always_comb begin
        wState_d = wState_q;
        wAddr_d  = wAddr_q;
        wLen_d   = wLen_q;
        wBurst_d = wBurst_q;
        wCnt_d   = wCnt_q;
        wrDone_d = 1'b0;
        case (wState_q)
            W_IDLE: begin
                if (wr_start) begin
                    wState_d = W_ACTIVE;
                    wAddr_d  = S_AXI_AWADDR;
                    wLen_d   = S_AXI_AWLEN;
                    wBurst_d = S_AXI_AWBURST;
                    wCnt_d   = 8'd0;
                end
            end
            W_ACTIVE: begin
                if (wBeat) begin
                    wAddr_d = stepAddr(wAddr_q, wLen_q, wBurst_q);
                    wCnt_d  = wCnt_q + 8'd1;
                    if (wCnt_q == wLen_q) begin
                        wState_d = W_IDLE;
                        wrDone_d = 1'b1;
                    end
                end
            end
            default: wState_d = W_IDLE;
        endcase
    end

    // Read FSM: each request produces one registered beat, and the last beat flags rd_last.
    always_comb begin
        rState_d  = rState_q;
        rAddr_d   = rAddr_q;
        rLen_d    = rLen_q;
        rBurst_d  = rBurst_q;
        rCnt_d    = rCnt_q;
        rdValid_d = rReq;
        rdLast_d  = 1'b0;
        rdData_d  = (rReq && !rOob) ? rdMerged : '0;
        case (rState_q)
            R_IDLE: begin
                if (rd_start) begin
                    rState_d = R_ACTIVE;
                    rAddr_d  = S_AXI_ARADDR;
                    rLen_d   = S_AXI_ARLEN;
                    rBurst_d = S_AXI_ARBURST;
                    rCnt_d   = 8'd0;
                end
            end
            R_ACTIVE: begin
                if (rReq) begin
                    rAddr_d = stepAddr(rAddr_q, rLen_q, rBurst_q);
                    rCnt_d  = rCnt_q + 8'd1;
                    if (rCnt_q == rLen_q) begin
                        rState_d = R_IDLE;
                        rdLast_d = 1'b1;
                    end
                end
            end
            default: rState_d = R_IDLE;
        endcase
    end

    // Out-of-range flag for any write beat or read beat that addresses a missing bank.
    always_comb begin
        oobErr_d = (wBeat && wOob) || (rReq && rOob);
    end

    // Write-side state register
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            wState_q <= W_IDLE;
            wAddr_q  <= '0;
            wLen_q   <= 8'd0;
            wBurst_q <= 2'b00;
            wCnt_q   <= 8'd0;
            wrDone_q <= 1'b0;
        end else begin
            wState_q <= wState_d;
            wAddr_q  <= wAddr_d;
            wLen_q   <= wLen_d;
            wBurst_q <= wBurst_d;
            wCnt_q   <= wCnt_d;
            wrDone_q <= wrDone_d;
        end
    end

    // Read-side state register and registered read outputs
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rState_q  <= R_IDLE;
            rAddr_q   <= '0;
            rLen_q    <= 8'd0;
            rBurst_q  <= 2'b00;
            rCnt_q    <= 8'd0;
            rdValid_q <= 1'b0;
            rdLast_q  <= 1'b0;
            rdData_q  <= '0;
            oobErr_q  <= 1'b0;
        end else begin
            rState_q  <= rState_d;
            rAddr_q   <= rAddr_d;
            rLen_q    <= rLen_d;
            rBurst_q  <= rBurst_d;
            rCnt_q    <= rCnt_d;
            rdValid_q <= rdValid_d;
            rdLast_q  <= rdLast_d;
            rdData_q  <= rdData_d;
            oobErr_q  <= oobErr_d;
        end
    end

    assign axi_rdata     = rdData_q;
    assign rd_data_valid = rdValid_q;
    assign rd_last       = rdLast_q;
    assign wr_done       = wrDone_q;
    assign oob_err       = oobErr_q;

endmodule

// File: tb/tb_axi4_banked_burst_ram.sv
// Directed bench for axi4_banked_burst_ram with three banks, so bank 3 is out of range.
// Decode at DW=32: word = addr[5:2], bank = addr[7:6], which gives 64 bytes per bank.
module tb_axi4_banked_burst_ram;

    localparam int AW = 10;
    localparam int DW = 32;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          wr_start;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [1:0]    awburst;
    logic          wvalid;
    logic          wready;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic          rd_start;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [1:0]    arburst;
    logic          rd_beat_req;
    logic [DW-1:0] axi_rdata;
    logic          rd_data_valid;
    logic          rd_last;
    logic          wr_done;
    logic          oob_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] wrData [16];
    logic [3:0]  wrStrb [16];
    logic [31:0] rdExp  [16];

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    axi4_banked_burst_ram #(
        .C_S_AXI_ADDR_WIDTH (AW),
        .C_S_AXI_DATA_WIDTH (DW),
        .OPT_MEM_ADDR_BITS  (3),
        .USER_NUM_MEM       (3)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (aresetn),
        .wr_start      (wr_start),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWLEN   (awlen),
        .S_AXI_AWBURST (awburst),
        .S_AXI_WVALID  (wvalid),
        .axi_wready    (wready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .rd_start      (rd_start),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARLEN   (arlen),
        .S_AXI_ARBURST (arburst),
        .rd_beat_req   (rd_beat_req),
        .axi_rdata     (axi_rdata),
        .rd_data_valid (rd_data_valid),
        .rd_last       (rd_last),
        .wr_done       (wr_done),
        .oob_err       (oob_err)
    );

    // Count one comparison and report it if the observed value is not the expected one
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to the n-th following falling edge, where inputs change and outputs are sampled
    task automatic applyStimulus(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One write burst from wrData/wrStrb, checking wr_done and oob_err after every beat
    task automatic writeBurst(input logic [AW-1:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic expOob);
        wr_start = 1'b1;
        awaddr   = addr;
        awlen    = len;
        awburst  = burst;
        applyStimulus(1);
        wr_start = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1;
            wready = 1'b1;
            wdata  = wrData[i];
            wstrb  = wrStrb[i];
            applyStimulus(1);
            checkOutput("wr_done_beat", 32'(wr_done), 32'(i == int'(len)));
            checkOutput("oob_err_wbeat", 32'(oob_err), 32'(expOob));
        end
        wvalid = 1'b0;
        wready = 1'b0;
        applyStimulus(1);
        checkOutput("wr_done_clear", 32'(wr_done), 32'd0);
        checkOutput("oob_err_wclear", 32'(oob_err), 32'd0);
    endtask

    // One read burst with back-to-back requests, comparing every beat against rdExp
    task automatic readBurst(input logic [AW-1:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic expOob);
        rd_start = 1'b1;
        araddr   = addr;
        arlen    = len;
        arburst  = burst;
        applyStimulus(1);
        rd_start    = 1'b0;
        rd_beat_req = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            applyStimulus(1);
            if (i == int'(len)) rd_beat_req = 1'b0;
            checkOutput("rd_valid_beat", 32'(rd_data_valid), 32'd1);
            checkOutput("rd_data_beat", axi_rdata, rdExp[i]);
            checkOutput("rd_last_beat", 32'(rd_last), 32'(i == int'(len)));
            checkOutput("oob_err_rbeat", 32'(oob_err), 32'(expOob));
        end
        applyStimulus(1);
        checkOutput("rd_valid_clear", 32'(rd_data_valid), 32'd0);
        checkOutput("rd_data_clear", axi_rdata, 32'd0);
        checkOutput("rd_last_clear", 32'(rd_last), 32'd0);
    endtask

    // Watchdog so that a stuck run still terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        aresetn     = 1'b0;
        wr_start    = 1'b0;
        awaddr      = '0;
        awlen       = 8'd0;
        awburst     = INCR;
        wvalid      = 1'b0;
        wready      = 1'b0;
        wdata       = '0;
        wstrb       = 4'h0;
        rd_start    = 1'b0;
        araddr      = '0;
        arlen       = 8'd0;
        arburst     = INCR;
        rd_beat_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wrData[i] = 32'h0;
            wrStrb[i] = 4'hF;
            rdExp[i]  = 32'h0;
        end

        applyStimulus(3);
        checkOutput("reset_rdata", axi_rdata, 32'd0);
        checkOutput("reset_valid", 32'(rd_data_valid), 32'd0);
        checkOutput("reset_last", 32'(rd_last), 32'd0);
        checkOutput("reset_wr_done", 32'(wr_done), 32'd0);
        checkOutput("reset_oob", 32'(oob_err), 32'd0);
        aresetn = 1'b1;
        applyStimulus(1);

        // T1: INCR write of four words, then INCR read-back
        $display("[TB] T1 INCR write/read");
        wrData[0] = 32'h11; wrData[1] = 32'h22; wrData[2] = 32'h33; wrData[3] = 32'h44;
        writeBurst(10'h000, 8'd3, INCR, 1'b0);
        rdExp[0] = 32'h11; rdExp[1] = 32'h22; rdExp[2] = 32'h33; rdExp[3] = 32'h44;
        readBurst(10'h000, 8'd3, INCR, 1'b0);

        // T2: WRAP read of four beats from 0x008 visits 0x8, 0xC, 0x0, 0x4
        $display("[TB] T2 WRAP read");
        rdExp[0] = 32'h33; rdExp[1] = 32'h44; rdExp[2] = 32'h11; rdExp[3] = 32'h22;
        readBurst(10'h008, 8'd3, WRAP, 1'b0);

        // T3: FIXED two-beat write to one word, where the second beat strobes bytes 0 and 2 only
        $display("[TB] T3 byte strobes");
        wrData[0] = 32'hAABBCCDD; wrStrb[0] = 4'hF;
        wrData[1] = 32'h11223344; wrStrb[1] = 4'b0101;
        writeBurst(10'h010, 8'd1, FIXED, 1'b0);
        wrStrb[1] = 4'hF;
        rdExp[0] = 32'hAA22CC44;
        readBurst(10'h010, 8'd0, INCR, 1'b0);

        // T4: same word index in banks 0, 1 and 2 must not alias
        $display("[TB] T4 bank decode");
        wrData[0] = 32'h5; writeBurst(10'h014, 8'd0, INCR, 1'b0);
        wrData[0] = 32'h6; writeBurst(10'h054, 8'd0, INCR, 1'b0);
        wrData[0] = 32'h7; writeBurst(10'h094, 8'd0, INCR, 1'b0);
        rdExp[0] = 32'h5; readBurst(10'h014, 8'd0, INCR, 1'b0);
        rdExp[0] = 32'h6; readBurst(10'h054, 8'd0, INCR, 1'b0);
        rdExp[0] = 32'h7; readBurst(10'h094, 8'd0, INCR, 1'b0);

        // T5: bank 3 is out of range, so the write is dropped and the read returns zero with valid
        $display("[TB] T5 out-of-range bank");
        wrData[0] = 32'hDEAD; writeBurst(10'h0D4, 8'd0, INCR, 1'b1);
        rdExp[0] = 32'h0;     readBurst(10'h0D4, 8'd0, INCR, 1'b1);
        rdExp[0] = 32'h5;     readBurst(10'h014, 8'd0, INCR, 1'b0);
        rdExp[0] = 32'h6;     readBurst(10'h054, 8'd0, INCR, 1'b0);
        rdExp[0] = 32'h7;     readBurst(10'h094, 8'd0, INCR, 1'b0);

        // T6a: write and read of the same word in the same cycle return the merged new data
        $display("[TB] T6 collision and mid-burst reset");
        wrData[0] = 32'h12345678; writeBurst(10'h018, 8'd0, INCR, 1'b0);
        wr_start = 1'b1; awaddr = 10'h018; awlen = 8'd0; awburst = INCR;
        rd_start = 1'b1; araddr = 10'h018; arlen = 8'd0; arburst = INCR;
        applyStimulus(1);
        wr_start = 1'b0; rd_start = 1'b0;
        wvalid = 1'b1; wready = 1'b1; wdata = 32'hA5A5A5A5; wstrb = 4'b0011;
        rd_beat_req = 1'b1;
        applyStimulus(1);
        wvalid = 1'b0; wready = 1'b0; rd_beat_req = 1'b0;
        checkOutput("coll_valid", 32'(rd_data_valid), 32'd1);
        checkOutput("coll_data", axi_rdata, 32'h1234A5A5);
        checkOutput("coll_last", 32'(rd_last), 32'd1);
        checkOutput("coll_wr_done", 32'(wr_done), 32'd1);
        applyStimulus(1);
        rdExp[0] = 32'h1234A5A5;
        readBurst(10'h018, 8'd0, INCR, 1'b0);

        // T6b: reset asserted in the middle of an eight-beat read
        rd_start = 1'b1; araddr = 10'h000; arlen = 8'd7; arburst = INCR;
        applyStimulus(1);
        rd_start    = 1'b0;
        rd_beat_req = 1'b1;
        rdExp[0] = 32'h11; rdExp[1] = 32'h22; rdExp[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("rst_pre_data", axi_rdata, rdExp[i]);
            checkOutput("rst_pre_last", 32'(rd_last), 32'd0);
        end
        aresetn = 1'b0;
        applyStimulus(1);
        checkOutput("rst_mid_valid", 32'(rd_data_valid), 32'd0);
        checkOutput("rst_mid_data", axi_rdata, 32'd0);
        aresetn = 1'b1;
        applyStimulus(1);
        checkOutput("rst_idle_valid", 32'(rd_data_valid), 32'd0);
        rd_beat_req = 1'b0;
        rdExp[0] = 32'h22;
        readBurst(10'h004, 8'd0, INCR, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
